// File: rtl/lcd_hd44780_writer.sv
// HD44780 16x2 writer: power-up init, character/space writes,
// clear, completion lock, cursor tracking with line wrap.
module lcd_hd44780_writer #(
  parameter int unsigned POWERUP_CYCLES    = 2_000_000,
  parameter int unsigned E_PULSE_CYCLES    = 50,
  parameter int unsigned CMD_WAIT_CYCLES   = 5_000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       db_enter_letter,
  input  logic       db_finish_word,
  input  logic       db_clear_display,
  input  logic       db_complete_input,
  output logic [7:0] lcd_db,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy,
  output logic [4:0] cursor_pos,
  output logic       done
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_EHIGH,
    S_WAIT,
    S_IDLE
  } state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [1:0]  init_idx, init_idx_n;
  logic        in_init, in_init_n;
  logic [7:0]  db_q, db_n;
  logic        rs_q, rs_n;
  logic        e_q, e_n;
  logic [4:0]  cur_q, cur_n;
  logic        done_q, done_n;
  logic [3:0]  prev;
  logic [3:0]  lvl;
  logic [3:0]  ev;
  logic [31:0] wait_lim;

  // bit order doubles as priority: clear, complete, letter, word
  assign lvl = {db_clear_display, db_complete_input,
                db_enter_letter, db_finish_word};
  assign ev  = lvl & ~prev;

  assign wait_lim = (!rs_q && db_q == 8'h01)
                  ? CLEAR_WAIT_CYCLES - 1
                  : CMD_WAIT_CYCLES - 1;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_PWRUP;
      cnt      <= '0;
      init_idx <= '0;
      in_init  <= 1'b0;
      db_q     <= '0;
      rs_q     <= 1'b0;
      e_q      <= 1'b0;
      cur_q    <= '0;
      done_q   <= 1'b0;
      prev     <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      init_idx <= init_idx_n;
      in_init  <= in_init_n;
      db_q     <= db_n;
      rs_q     <= rs_n;
      e_q      <= e_n;
      cur_q    <= cur_n;
      done_q   <= done_n;
      prev     <= lvl;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    init_idx_n = init_idx;
    in_init_n  = in_init;
    db_n       = db_q;
    rs_n       = rs_q;
    e_n        = 1'b0;
    cur_n      = cur_q;
    done_n     = done_q;
    case (state)
      S_PWRUP: begin
        if (cnt == POWERUP_CYCLES - 1) begin
          state_n    = S_SETUP;
          cnt_n      = '0;
          init_idx_n = 2'd0;
          in_init_n  = 1'b1;
          db_n       = init_cmd(2'd0);
          rs_n       = 1'b0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_SETUP: begin
        state_n = S_EHIGH;
        cnt_n   = '0;
        e_n     = 1'b1;
      end
      S_EHIGH: begin
        if (cnt == E_PULSE_CYCLES - 1) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 32'd1;
          e_n   = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == wait_lim) begin
          cnt_n   = '0;
          state_n = S_IDLE;
          if (in_init) begin
            if (init_idx == 2'd3) begin
              in_init_n = 1'b0;
            end else begin
              init_idx_n = init_idx + 2'd1;
              db_n       = init_cmd(init_idx + 2'd1);
              state_n    = S_SETUP;
            end
          end else if (rs_q) begin
            // data write done: advance cursor, re-address on line change
            if (cur_q == 5'd15) begin
              cur_n   = 5'd16;
              db_n    = 8'hC0;
              rs_n    = 1'b0;
              state_n = S_SETUP;
            end else if (cur_q == 5'd31) begin
              cur_n   = 5'd0;
              db_n    = 8'h80;
              rs_n    = 1'b0;
              state_n = S_SETUP;
            end else begin
              cur_n = cur_q + 5'd1;
            end
          end
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      default: begin
        if (ev[3]) begin
          cur_n   = 5'd0;
          done_n  = 1'b0;
          db_n    = 8'h01;
          rs_n    = 1'b0;
          state_n = S_SETUP;
        end else if (ev[2]) begin
          done_n = 1'b1;
        end else if (ev[1]) begin
          if (!done_q) begin
            db_n    = char_in;
            rs_n    = 1'b1;
            state_n = S_SETUP;
          end
        end else if (ev[0]) begin
          if (!done_q) begin
            db_n    = 8'h20;
            rs_n    = 1'b1;
            state_n = S_SETUP;
          end
        end
      end
    endcase
  end

  assign lcd_db     = db_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = e_q;
  assign busy       = (state != S_IDLE);
  assign cursor_pos = cur_q;
  assign done       = done_q;

endmodule
